// File: rtl/coreriscv_axi4_id_tracker.sv
// AXI4 ID tracker: counts outstanding transactions per master ID, gates new
// requests at the per-ID limit and flags response completions that match nothing.
module coreriscv_axi4_id_tracker #(
    parameter int IN_ID_W  = 2,
    parameter int OUT_ID_W = 5,
    parameter int MAX_OUT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_req_valid,
    output logic                io_req_ready,
    input  logic [IN_ID_W-1:0]  io_req_in_id,
    output logic [OUT_ID_W-1:0] io_req_out_id,
    input  logic                io_resp_valid,
    input  logic                io_resp_ready,
    input  logic                io_resp_last,
    input  logic [OUT_ID_W-1:0] io_resp_out_id,
    output logic [IN_ID_W-1:0]  io_resp_in_id,
    output logic                io_resp_matches,
    output logic                io_idle,
    output logic                io_err
);

    localparam int         NUM_IDS = 1 << IN_ID_W;
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    logic [2:0]         cnt_q [NUM_IDS];
    logic [2:0]         cnt_d [NUM_IDS];
    logic               err_q;
    logic               err_d;
    logic               req_fire_s;
    logic               resp_done_s;
    logic               hi_zero_s;
    logic               matches_s;
    logic               busy_s;
    logic [IN_ID_W-1:0] resp_id_s;

    assign resp_id_s   = io_resp_out_id[IN_ID_W-1:0];
    assign hi_zero_s   = (io_resp_out_id[OUT_ID_W-1:IN_ID_W] == '0);
    assign matches_s   = hi_zero_s && (cnt_q[resp_id_s] != 3'd0);
    assign req_fire_s  = io_req_valid && io_req_ready;
    assign resp_done_s = io_resp_valid && io_resp_ready && io_resp_last;

    assign io_req_ready    = (cnt_q[io_req_in_id] != MAX_CNT);
    assign io_req_out_id   = {{(OUT_ID_W-IN_ID_W){1'b0}}, io_req_in_id};
    assign io_resp_in_id   = resp_id_s;
    assign io_resp_matches = matches_s;
    assign io_idle         = ~busy_s;
    assign io_err          = err_q;

    // Any non-zero counter means work is outstanding.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            busy_s = busy_s | (cnt_q[i] != 3'd0);
        end
    end

    // Per-ID counter update; a simultaneous increment and decrement cancel.
    always_comb begin
        for (int i = 0; i < NUM_IDS; i++) begin
            case ({req_fire_s && (io_req_in_id == IN_ID_W'(i)),
                   resp_done_s && matches_s && (resp_id_s == IN_ID_W'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + 3'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 3'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        err_d = err_q | (resp_done_s & ~matches_s);
    end

    // State registers; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt_q[i] <= 3'd0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_coreriscv_axi4_id_tracker.sv
// Self-checking bench for coreriscv_axi4_id_tracker: directed scenarios plus
// randomized traffic checked against a per-ID outstanding-count model.
module tb_coreriscv_axi4_id_tracker;

    localparam int MAX_OUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_in_id;
    logic [4:0] req_out_id;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_last;
    logic [4:0] resp_out_id;
    logic [1:0] resp_in_id;
    logic       resp_matches;
    logic       idle;
    logic       err;

    int checks   = 0;
    int failures = 0;

    int mcnt [4];
    bit merr;

    coreriscv_axi4_id_tracker #(.IN_ID_W(2), .OUT_ID_W(5), .MAX_OUT(MAX_OUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .io_req_valid    (req_valid),
        .io_req_ready    (req_ready),
        .io_req_in_id    (req_in_id),
        .io_req_out_id   (req_out_id),
        .io_resp_valid   (resp_valid),
        .io_resp_ready   (resp_ready),
        .io_resp_last    (resp_last),
        .io_resp_out_id  (resp_out_id),
        .io_resp_in_id   (resp_in_id),
        .io_resp_matches (resp_matches),
        .io_idle         (idle),
        .io_err          (err)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready(int id);
        return mcnt[id] < MAX_OUT;
    endfunction

    function automatic bit m_match(logic [4:0] oid);
        return (oid / 4 == 0) && (mcnt[oid % 4] > 0);
    endfunction

    function automatic bit m_idle();
        return (mcnt[0] + mcnt[1] + mcnt[2] + mcnt[3]) == 0;
    endfunction

    task automatic drive(bit rv, int rid, bit sv, bit sr, bit sl, int soid);
        req_valid   = rv;
        req_in_id   = 2'(rid);
        resp_valid  = sv;
        resp_ready  = sr;
        resp_last   = sl;
        resp_out_id = 5'(soid);
    endtask

    // Advance one clock; the model applies the transfer rules to pre-edge inputs.
    task automatic tick();
        bit acc, done, match;
        int rid, sid;
        rid   = int'(req_in_id);
        sid   = int'(resp_out_id) % 4;
        acc   = req_valid && m_ready(rid);
        done  = resp_valid && resp_ready && resp_last;
        match = m_match(resp_out_id);
        @(posedge clk);
        if (acc) mcnt[rid] = mcnt[rid] + 1;
        if (done && match) mcnt[sid] = mcnt[sid] - 1;
        if (done && !match) merr = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        merr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", idle); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++;
        if (resp_matches !== 1'b0) begin failures++; $display("FAIL reset_matches: got %b expected 0", resp_matches); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            drive(1, 2, 0, 0, 0, 0);
            #1;
            checks++;
            if (req_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d: got %b expected 1", k, req_ready); end
            checks++;
            if (req_out_id !== 5'b00010) begin failures++; $display("FAIL fill_out_id: got %b expected 00010", req_out_id); end
            tick();
        end
        drive(1, 2, 0, 0, 0, 0);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL full_ready_id2: got %b expected 0", req_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL full_ready_id0: got %b expected 1", req_ready); end
        drive(0, 2, 0, 0, 0, 0);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL full_still_id2: got %b expected 0", req_ready); end
    endtask

    task automatic test_multibeat();
        // A last beat the master does not accept must not count.
        drive(0, 2, 1, 0, 1, 2);
        tick();
        for (int b = 1; b <= 3; b++) begin
            drive(0, 2, 1, 1, (b == 3), 2);
            #1;
            checks++;
            if (req_ready !== 1'b0) begin failures++; $display("FAIL beat%0d_ready: got %b expected 0", b, req_ready); end
            checks++;
            if (resp_matches !== 1'b1) begin failures++; $display("FAIL beat%0d_matches: got %b expected 1", b, resp_matches); end
            checks++;
            if (resp_in_id !== 2'd2) begin failures++; $display("FAIL beat%0d_in_id: got %0d expected 2", b, resp_in_id); end
            tick();
        end
        drive(0, 2, 0, 0, 0, 0);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL after_last_ready: got %b expected 1", req_ready); end
        // Refill to 4 then confirm the slot closes again.
        drive(1, 2, 0, 0, 0, 0);
        tick();
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL refill_ready: got %b expected 0", req_ready); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1, 1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 1, 1, 1);
        #1;
        checks++;
        if (resp_matches !== 1'b1) begin failures++; $display("FAIL same_matches: got %b expected 1", resp_matches); end
        tick();
        drive(0, 1, 0, 0, 0, 1);
        #1;
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL same_idle: got %b expected 0", idle); end
        checks++;
        if (resp_matches !== 1'b1) begin failures++; $display("FAIL same_cnt_nonzero: got %b expected 1", resp_matches); end
        drive(0, 1, 1, 1, 1, 1);
        tick();
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL same_cnt_was_one: got idle %b expected 1", idle); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL same_err: got %b expected 0", err); end
    endtask

    task automatic test_unmatched();
        do_reset();
        drive(0, 0, 1, 1, 1, 5'b00011);
        #1;
        checks++;
        if (resp_matches !== 1'b0) begin failures++; $display("FAIL unm1_matches: got %b expected 0", resp_matches); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL unm1_err_early: got %b expected 0", err); end
        tick();
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL unm1_err: got %b expected 1", err); end
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 1, 5'b01000);
        #1;
        checks++;
        if (resp_matches !== 1'b0) begin failures++; $display("FAIL unm2_matches: got %b expected 0", resp_matches); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL unm2_err: got %b expected 1", err); end
        checks++;
        if (resp_matches !== 1'b1) begin failures++; $display("FAIL unm2_cnt_kept: got %b expected 1", resp_matches); end
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL unm2_idle: got %b expected 0", idle); end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        merr = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL async_idle: got %b expected 1", idle); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL async_err: got %b expected 0", err); end
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 1, 1, 1, 0);
        #1;
        checks++;
        if (resp_matches !== 1'b0) begin failures++; $display("FAIL post_reset_matches: got %b expected 0", resp_matches); end
        tick();
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL post_reset_err: got %b expected 1", err); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)));
            #1;
            checks++;
            if (req_ready !== m_ready(int'(req_in_id))) begin
                failures++; $display("FAIL rnd_ready @%0d: got %b expected %b", n, req_ready, m_ready(int'(req_in_id)));
            end
            checks++;
            if (req_out_id !== {3'b000, req_in_id}) begin
                failures++; $display("FAIL rnd_out_id @%0d: got %b expected %b", n, req_out_id, {3'b000, req_in_id});
            end
            checks++;
            if (resp_in_id !== resp_out_id[1:0]) begin
                failures++; $display("FAIL rnd_in_id @%0d: got %0d expected %0d", n, resp_in_id, resp_out_id[1:0]);
            end
            checks++;
            if (resp_matches !== m_match(resp_out_id)) begin
                failures++; $display("FAIL rnd_matches @%0d: got %b expected %b", n, resp_matches, m_match(resp_out_id));
            end
            checks++;
            if (idle !== m_idle()) begin
                failures++; $display("FAIL rnd_idle @%0d: got %b expected %b", n, idle, m_idle());
            end
            checks++;
            if (err !== merr) begin
                failures++; $display("FAIL rnd_err @%0d: got %b expected %b", n, err, merr);
            end
            tick();
            // Occasionally reset mid-traffic to clear the sticky error.
            if (err && $urandom_range(0, 15) == 0) do_reset();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        merr = 1'b0;
        test_reset();
        test_fill();
        test_multibeat();
        test_same_cycle();
        test_unmatched();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coreriscv_axi4_id_tracker.md
CORERISCV_AXI4_ID_TRACKER -- requirements
Module: coreriscv_axi4_id_tracker

Interface
REQ-001 SHALL have parameter IN_ID_W, default 2, master-side ID width.
REQ-002 SHALL have parameter OUT_ID_W, default 5, fabric-side ID width; OUT_ID_W > IN_ID_W.
REQ-003 SHALL have parameter MAX_OUT, default 4, per-ID outstanding-transaction limit; legal range 1..7; counters are 3 bits wide.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset; assertion clears state immediately, deassertion is synchronised externally.
REQ-006 SHALL have port io_req_valid, input, 1, master presents a request (AR or AW).
REQ-007 SHALL have port io_req_ready, output, 1, tracker accepts the request.
REQ-008 SHALL have port io_req_in_id, input, IN_ID_W, master ID.
REQ-009 SHALL have port io_req_out_id, output, OUT_ID_W, fabric ID, zero-extended io_req_in_id.
REQ-010 SHALL have port io_resp_valid, input, 1, fabric presents a response beat (R or B).
REQ-011 SHALL have port io_resp_ready, input, 1, master accepts the response beat.
REQ-012 SHALL have port io_resp_last, input, 1, final beat of the response; tied 1 for B channel.
REQ-013 SHALL have port io_resp_out_id, input, OUT_ID_W, fabric ID of the response.
REQ-014 SHALL have port io_resp_in_id, output, IN_ID_W, io_resp_out_id[IN_ID_W-1:0].
REQ-015 SHALL have port io_resp_matches, output, 1, response ID has outstanding work.
REQ-016 SHALL have port io_idle, output, 1, no transaction outstanding on any ID.
REQ-017 SHALL have port io_err, output, 1, sticky flag: an unmatched final beat completed.

Function
REQ-018 SHALL keep one 3-bit counter cnt[i] per ID value i, 0..2^IN_ID_W-1.
REQ-019 SHALL define req_fire = io_req_valid & io_req_ready.
REQ-020 SHALL define resp_done = io_resp_valid & io_resp_ready & io_resp_last.
REQ-021 SHALL drive io_req_ready = (cnt[io_req_in_id] != MAX_OUT), combinationally from state only; no dependency on io_req_valid.
REQ-022 SHALL drive io_req_out_id = {zeros, io_req_in_id} combinationally, zero latency.
REQ-023 SHALL drive io_resp_matches = 1 when upper OUT_ID_W-IN_ID_W bits of io_resp_out_id are zero and cnt[io_resp_in_id] != 0, else 0.
REQ-024 SHALL increment cnt[io_req_in_id] by 1 on the edge after req_fire; the count is visible the next cycle.
REQ-025 SHALL decrement cnt[io_resp_in_id] by 1 on the edge after resp_done when io_resp_matches = 1.
REQ-026 SHALL leave counters unchanged by non-last beats and by beats without io_resp_ready.
REQ-027 SHALL leave the counter unchanged when req_fire and matched resp_done target the same ID in the same cycle.
REQ-028 SHALL apply both updates independently when req_fire and resp_done target different IDs in the same cycle.
REQ-029 SHALL never let a counter exceed MAX_OUT or wrap below 0.
REQ-030 SHALL set io_err on the edge after resp_done with io_resp_matches = 0, leave counters unchanged, and hold io_err until reset.
REQ-031 SHALL drive io_idle = 1 when all counters equal 0, combinationally from state.
REQ-032 SHALL accept a request at cnt = MAX_OUT-1 and deassert io_req_ready for that ID the following cycle; other IDs are unaffected.
REQ-033 SHALL allow a request whose cnt = MAX_OUT in a given cycle only after a matched resp_done on that ID, with io_req_ready reasserting the next cycle.

Reset
REQ-034 SHALL, while reset = 0, clear all counters and io_err; outputs then read io_req_ready = 1, io_idle = 1, io_err = 0, io_resp_matches = 0.
REQ-035 SHALL discard outstanding counts when reset asserts mid-transaction; responses arriving after release report io_resp_matches = 0 and set io_err on completion.

Verification
REQ-036 Scenario: reset low then high, all inputs 0 -> io_req_ready = 1, io_idle = 1, io_err = 0.
REQ-037 Scenario: 4 requests on ID 2 in 4 consecutive cycles with MAX_OUT = 4 -> the 4th is accepted; io_req_ready = 0 for ID 2, 1 for ID 0; io_req_out_id = 5'b00010.
REQ-038 Scenario: ID 2 full; one read response on ID 2, 3 beats, last on beat 3 -> cnt stays at 4 through beats 1-2, drops to 3 after beat 3, and io_req_ready reasserts for ID 2 the next cycle.
REQ-039 Scenario: cnt[1] = 1; req_fire ID 1 and matched resp_done ID 1 in the same cycle -> cnt[1] remains 1 and io_idle = 0.
REQ-040 Scenario: io_idle = 1; resp_done on out_id 5'b00011, then on 5'b01000 -> io_resp_matches = 0 for both, io_err = 1 from the cycle after the first beat and stays 1, counters unchanged.
REQ-041 Scenario: 2 outstanding requests on ID 0, reset pulsed low -> io_idle = 1 and io_err = 0 immediately, without waiting for a clock edge.
